// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: operation classes, per-class
// opcodes, memory request codes and default widths.
package exe_pkg;

  localparam int EXE_DW = 16;
  localparam int EXE_AW = 4;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_RSV2  = 3'b010,
    SEL_ARITH = 3'b011,
    SEL_MEM   = 3'b100,
    SEL_MOVE  = 3'b101,
    SEL_SHIFT = 3'b110,
    SEL_RSV7  = 3'b111
  } alusel_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } memrw_e;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_MOVA = 3'b100;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;

  localparam logic [2:0] OP_MV_A = 3'b000;
  localparam logic [2:0] OP_MV_B = 3'b001;
  localparam logic [2:0] OP_NEG  = 3'b010;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SRAV = 3'b011;

  // A 3-bit shift field of zero encodes a shift by eight.
  function automatic logic [3:0] fixed_shamt(input logic [2:0] field);
    return (field == 3'd0) ? 4'd8 : {1'b0, field};
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Decode-to-execute operand bundle and execute-to-memory result bundle.
interface exe_stage_if
  import exe_pkg::*;
#(
  parameter int DW = EXE_DW,
  parameter int AW = EXE_AW
);
  logic [2:0]    aluop_i;
  logic [2:0]    alusel_i;
  logic [DW-1:0] reg0_i;
  logic [DW-1:0] reg1_i;
  logic [AW-1:0] waddr_i;
  logic          we_i;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic [1:0]    memrw_o;
  logic [DW-1:0] memaddr_o;

  modport slave (
    input  aluop_i, alusel_i, reg0_i, reg1_i, waddr_i, we_i,
    output we_o, waddr_o, wdata_o, memrw_o, memaddr_o
  );

  modport master (
    output aluop_i, alusel_i, reg0_i, reg1_i, waddr_i, we_i,
    input  we_o, waddr_o, wdata_o, memrw_o, memaddr_o
  );
endinterface

// File: rtl/exe_alu.sv
// Combinational execute datapath: maps class/op and two operands onto the
// write-back result, write enable and memory request.
module exe_alu
  import exe_pkg::*;
#(
  parameter int DW = EXE_DW
) (
  input  logic [2:0]    alusel_i,
  input  logic [2:0]    aluop_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          we_i,
  output logic [DW-1:0] result_o,
  output logic          we_o,
  output logic [1:0]    memrw_o,
  output logic [DW-1:0] memaddr_o
);

  logic [3:0] sa_s;

  // Result selection by class, then by opcode within the class.
  always_comb begin
    result_o  = {DW{1'b0}};
    we_o      = we_i;
    memrw_o   = MEM_NONE;
    memaddr_o = {DW{1'b0}};
    sa_s      = fixed_shamt(b_i[2:0]);
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  result_o = a_i & b_i;
          OP_OR:   result_o = a_i | b_i;
          OP_XOR:  result_o = a_i ^ b_i;
          OP_NOT:  result_o = ~a_i;
          OP_MOVA: result_o = a_i;
          default: result_o = {DW{1'b0}};
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADD:  result_o = a_i + b_i;
          OP_SUB:  result_o = a_i - b_i;
          OP_SLT:  result_o = {{(DW-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
          OP_SLTU: result_o = {{(DW-1){1'b0}}, (a_i < b_i)};
          OP_CMP:  result_o = {{(DW-1){1'b0}}, (a_i != b_i)};
          default: result_o = {DW{1'b0}};
        endcase
      end
      SEL_MEM: begin
        case (aluop_i)
          OP_LOAD: begin
            memrw_o   = MEM_READ;
            memaddr_o = a_i;
          end
          OP_STORE: begin
            memrw_o   = MEM_WRITE;
            memaddr_o = a_i;
            result_o  = b_i;
            we_o      = 1'b0;
          end
          default: we_o = 1'b0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MV_A: result_o = a_i;
          OP_MV_B: result_o = b_i;
          OP_NEG:  result_o = {DW{1'b0}} - a_i;
          default: result_o = {DW{1'b0}};
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result_o = a_i << sa_s;
          OP_SRL:  result_o = a_i >> sa_s;
          OP_SRA:  result_o = $signed(a_i) >>> sa_s;
          OP_SRAV: result_o = $signed(a_i) >>> b_i[3:0];
          default: result_o = {DW{1'b0}};
        endcase
      end
      default: we_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU followed by the EX/MEM output register,
// which clears on reset and holds while the pipeline is stalled.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DW = EXE_DW,
  parameter int AW = EXE_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallreq,
  exe_stage_if.slave    bus
);

  logic [DW-1:0] wdata_d, memaddr_d;
  logic [DW-1:0] wdata_q, memaddr_q;
  logic [1:0]    memrw_d, memrw_q;
  logic          we_d, we_q;
  logic [AW-1:0] waddr_q;

  exe_alu #(.DW(DW)) u_alu (
    .alusel_i  (bus.alusel_i),
    .aluop_i   (bus.aluop_i),
    .a_i       (bus.reg0_i),
    .b_i       (bus.reg1_i),
    .we_i      (bus.we_i),
    .result_o  (wdata_d),
    .we_o      (we_d),
    .memrw_o   (memrw_d),
    .memaddr_o (memaddr_d)
  );

  // EX/MEM register: reset wins over stall, stall holds every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      waddr_q   <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      memrw_q   <= MEM_NONE;
      memaddr_q <= {DW{1'b0}};
    end else if (!stallreq) begin
      we_q      <= we_d;
      waddr_q   <= bus.waddr_i;
      wdata_q   <= wdata_d;
      memrw_q   <= memrw_d;
      memaddr_q <= memaddr_d;
    end
  end

  assign bus.we_o      = we_q;
  assign bus.waddr_o   = waddr_q;
  assign bus.wdata_o   = wdata_q;
  assign bus.memrw_o   = memrw_q;
  assign bus.memaddr_o = memaddr_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed plus randomized bench for exe_stage against an arithmetic
// reference model of the execute-stage rules.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst;
  logic stallreq;

  exe_stage_if #(.DW(16), .AW(4)) bus ();

  exe_stage #(.DW(16), .AW(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .stallreq (stallreq),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  memrw;
    logic [15:0] memaddr;
  } exp_t;

  exp_t exp_q;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(int sel, int op, int a, int b, int wa, int we);
    exp_t r;
    int as, bs, sa, w, ma, mrw, wen;
    as  = (a >= 32768) ? a - 65536 : a;
    bs  = (b >= 32768) ? b - 65536 : b;
    sa  = ((b % 8) == 0) ? 8 : (b % 8);
    w   = 0;
    ma  = 0;
    mrw = 0;
    wen = we;
    case (sel)
      1: case (op)
           0: w = a & b;
           1: w = a | b;
           2: w = a ^ b;
           3: w = 65535 - a;
           4: w = a;
           default: w = 0;
         endcase
      3: case (op)
           0: w = (a + b) % 65536;
           1: w = (a - b + 65536) % 65536;
           2: w = (as < bs) ? 1 : 0;
           3: w = (a < b) ? 1 : 0;
           4: w = (a == b) ? 0 : 1;
           default: w = 0;
         endcase
      4: if (op == 0) begin
           mrw = 1; ma = a;
         end else if (op == 1) begin
           mrw = 2; ma = a; w = b; wen = 0;
         end else begin
           wen = 0;
         end
      5: case (op)
           0: w = a;
           1: w = b;
           2: w = (65536 - a) % 65536;
           default: w = 0;
         endcase
      6: case (op)
           0: w = (a * (1 << sa)) % 65536;
           1: w = a / (1 << sa);
           2: w = (as >>> sa) & 65535;
           3: w = (as >>> (b % 16)) & 65535;
           default: w = 0;
         endcase
      default: wen = 0;
    endcase
    r.we      = wen[0];
    r.waddr   = wa[3:0];
    r.wdata   = w[15:0];
    r.memrw   = mrw[1:0];
    r.memaddr = ma[15:0];
    return r;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(int sel, int op, int a, int b, int wa, int we, int st, int rs);
    bus.alusel_i = sel[2:0];
    bus.aluop_i  = op[2:0];
    bus.reg0_i   = a[15:0];
    bus.reg1_i   = b[15:0];
    bus.waddr_i  = wa[3:0];
    bus.we_i     = we[0];
    stallreq     = st[0];
    rst          = rs[0];
    @(posedge clk);
    if (rs != 0) exp_q = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h0000};
    else if (st == 0) exp_q = model(sel, op, a, b, wa, we);
    #1;
    chk("we",      {15'h0, bus.we_o},  {15'h0, exp_q.we});
    chk("waddr",   {12'h0, bus.waddr_o}, {12'h0, exp_q.waddr});
    chk("wdata",   bus.wdata_o,        exp_q.wdata);
    chk("memrw",   {14'h0, bus.memrw_o}, {14'h0, exp_q.memrw});
    chk("memaddr", bus.memaddr_o,      exp_q.memaddr);
  endtask

  initial begin
    logic [15:0] arith_exp [5];
    arith_exp[0] = 16'd9;
    arith_exp[1] = 16'd7;
    arith_exp[2] = 16'd0;
    arith_exp[3] = 16'd0;
    arith_exp[4] = 16'd1;
    exp_q = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h0000};

    apply(3, 0, 16'h1234, 16'h4321, 5, 1, 0, 1);
    apply(4, 1, 16'hBEEF, 16'hCAFE, 7, 1, 1, 1);
    chk("rst_wdata",   bus.wdata_o, 16'h0000);
    chk("rst_we",      {15'h0, bus.we_o}, 16'h0000);
    chk("rst_memrw",   {14'h0, bus.memrw_o}, 16'h0000);
    chk("rst_memaddr", bus.memaddr_o, 16'h0000);

    apply(0, 0, 5, 6, 3, 1, 0, 0);
    chk("nop_we",    {15'h0, bus.we_o}, 16'h0000);
    chk("nop_wdata", bus.wdata_o, 16'h0000);

    for (int op = 0; op < 5; op++) begin
      apply(3, op, 8, 1, 1, 1, 0, 0);
      chk("arith_wdata", bus.wdata_o, arith_exp[op]);
      chk("arith_waddr", {12'h0, bus.waddr_o}, 16'h0001);
      chk("arith_we",    {15'h0, bus.we_o}, 16'h0001);
    end
    apply(3, 2, 16'hFFFF, 1, 1, 1, 0, 0);
    chk("slt_neg", bus.wdata_o, 16'h0001);
    apply(3, 3, 16'hFFFF, 1, 1, 1, 0, 0);
    chk("sltu_big", bus.wdata_o, 16'h0000);

    apply(6, 0, 16'h807F, 0, 2, 1, 0, 0);
    chk("sll8", bus.wdata_o, 16'h7F00);
    apply(6, 1, 16'h807F, 1, 2, 1, 0, 0);
    chk("srl1", bus.wdata_o, 16'h403F);
    apply(6, 2, 16'h807F, 0, 2, 1, 0, 0);
    chk("sra8", bus.wdata_o, 16'hFF80);
    apply(6, 3, 16'h807F, 4, 2, 1, 0, 0);
    chk("srav4", bus.wdata_o, 16'hF807);

    apply(4, 0, 8, 0, 3, 1, 0, 0);
    chk("load_memrw",   {14'h0, bus.memrw_o}, 16'h0001);
    chk("load_memaddr", bus.memaddr_o, 16'h0008);
    apply(4, 1, 1, 16'h1234, 3, 1, 0, 0);
    chk("store_memrw",   {14'h0, bus.memrw_o}, 16'h0002);
    chk("store_memaddr", bus.memaddr_o, 16'h0001);
    chk("store_wdata",   bus.wdata_o, 16'h1234);
    chk("store_we",      {15'h0, bus.we_o}, 16'h0000);

    apply(3, 0, 3, 4, 2, 1, 0, 0);
    chk("add_pre_stall", bus.wdata_o, 16'h0007);
    apply(1, 2, 16'hAAAA, 16'h5555, 9, 0, 1, 0);
    apply(4, 0, 16'h0040, 16'h0000, 9, 1, 1, 0);
    apply(6, 0, 16'h0001, 16'h0003, 9, 1, 1, 0);
    chk("stall_wdata", bus.wdata_o, 16'h0007);
    chk("stall_memrw", {14'h0, bus.memrw_o}, 16'h0000);
    chk("stall_waddr", {12'h0, bus.waddr_o}, 16'h0002);
    apply(3, 0, 3, 4, 2, 1, 1, 1);
    chk("rst_in_stall", bus.wdata_o, 16'h0000);
    chk("rst_in_stall_we", {15'h0, bus.we_o}, 16'h0000);
    apply(3, 1, 5, 3, 6, 1, 0, 0);
    chk("post_stall_sub", bus.wdata_o, 16'h0002);

    for (int i = 0; i < 400; i++) begin
      int st, rs;
      st = ($urandom_range(0, 4) == 0) ? 1 : 0;
      rs = ($urandom_range(0, 31) == 0) ? 1 : 0;
      apply($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535),
            $urandom_range(0, 65535), $urandom_range(0, 15), $urandom_range(0, 1), st, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
